jtframe_tilescan: RTL

Tile-map scan engine that feeds the line-buffer writer with pixel data. It answers the writer's (hscan, vscan) pixel requests by reading the tile map and fetching 8-pixel 4bpp tile rows from SDRAM. It returns each pixel as {palette, colour index} with a pixel-valid flag. That flag is the `rom_ok` the line buffer qualifies its writes with. The block sits between the tile map RAM, the SDRAM ROM port and the line buffer, in the pixel clock domain.

---
 rtl/jtframe_tilescan_pkg.sv | 25 ++
 rtl/jtframe_tilescan_cache.sv | 76 +++++++
 rtl/jtframe_tilescan.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jtframe_tilescan_pkg.sv
// Shared jtframe video definitions for the tile scan engine: FSM states,
// tile geometry and the 4bpp nibble ordering of a ROM tile row.
package jtframe_tilescan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MAPWAIT = 2'd1,
        ST_ROMREQ  = 2'd2,
        ST_ROMWAIT = 2'd3
    } tilescan_st_t;

    localparam int TILE_PXL  = 8;
    localparam int TILE_ROWS = 8;

    // Pixel 0 of a tile row lives in bits 31:28 of the ROM word.
    localparam bit NIBBLE_MSB_FIRST = 1'b1;

    function automatic logic [3:0] tile_nibble(input logic [31:0] row,
                                               input logic [2:0]  idx);
        logic [4:0] base;
        base = NIBBLE_MSB_FIRST ? {~idx, 2'b00} : {idx, 2'b00};
        return row[base +: 4];
    endfunction

endpackage

// File: rtl/jtframe_tilescan_cache.sv
// One-row tile cache: request key, palette/flip/row data, hit flag and pixel mux.
// JTFRAME_TILESCAN_FLIP_EN adds the horizontal flip register and i_flip port.
module jtframe_tilescan_cache
    import jtframe_tilescan_pkg::*;
#(
    parameter int HKW  = 5,
    parameter int KW   = 13,
    parameter int PALW = 4,
    parameter int PW   = PALW + 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [KW-1:0]   i_key,
    input  logic            i_key_ld,
    input  logic [PALW-1:0] i_pal,
`ifdef JTFRAME_TILESCAN_FLIP_EN
    input  logic            i_flip,
`endif
    input  logic            i_meta_ld,
    input  logic [31:0]     i_data,
    input  logic            i_data_ld,
    input  logic [2:0]      i_idx,
    output logic            o_hit,
    output logic [2:0]      o_row,
    output logic [PW-1:0]   o_pxl
);

    logic [KW-1:0]   r_key;
    logic            r_valid;
    logic [PALW-1:0] r_pal;
    logic [31:0]     r_data;
    logic [2:0]      w_idx;
`ifdef JTFRAME_TILESCAN_FLIP_EN
    logic            r_flip;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key   <= '0;
            r_valid <= 1'b0;
            r_pal   <= '0;
            r_data  <= '0;
`ifdef JTFRAME_TILESCAN_FLIP_EN
            r_flip  <= 1'b0;
`endif
        end else begin
            // A new key always invalidates the row until its data lands.
            if (i_key_ld) begin
                r_key   <= i_key;
                r_valid <= 1'b0;
            end else if (i_data_ld) begin
                r_valid <= 1'b1;
            end
            if (i_meta_ld) begin
                r_pal  <= i_pal;
`ifdef JTFRAME_TILESCAN_FLIP_EN
                r_flip <= i_flip;
`endif
            end
            if (i_data_ld) begin
                r_data <= i_data;
            end
        end
    end

`ifdef JTFRAME_TILESCAN_FLIP_EN
    assign w_idx = r_flip ? ~i_idx : i_idx;
`else
    assign w_idx = i_idx;
`endif

    assign o_hit = r_valid && (r_key == i_key);
    assign o_row = r_key[HKW +: 3];
    assign o_pxl = {r_pal, tile_nibble(r_data, w_idx)};

endmodule

// File: rtl/jtframe_tilescan.sv
// Tile-map scan engine: answers (hscan, vscan) pixel requests from a cached
// tile row, refilling it via the tile map RAM and SDRAM ROM port on a miss.
// JTFRAME_TILESCAN_FLIP_EN widens map_data by an hflip MSB.
module jtframe_tilescan
    import jtframe_tilescan_pkg::*;
#(
    parameter int HW    = 8,
    parameter int VW    = 8,
    parameter int PALW  = 4,
    parameter int CODEW = 10,
    parameter int PW    = PALW + 4,
    parameter int MAPAW = (HW - 3) + (VW - 3),
    parameter int ROMAW = CODEW + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [HW-1:0]    hscan,
    input  logic [VW-1:0]    vscan,
    output logic [PW-1:0]    pxl_data,
    output logic             pxl_ok,
    output logic [MAPAW-1:0] map_addr,
`ifdef JTFRAME_TILESCAN_FLIP_EN
    input  logic [CODEW+PALW:0]   map_data,
`else
    input  logic [CODEW+PALW-1:0] map_data,
`endif
    output logic [ROMAW-1:0] rom_addr,
    output logic             rom_cs,
    input  logic             rom_ok,
    input  logic [31:0]      rom_data
);

    localparam int PXB  = $clog2(TILE_PXL);
    localparam int ROWB = $clog2(TILE_ROWS);
    localparam int HKW  = HW - PXB;
    localparam int KW   = VW + HKW;

    tilescan_st_t r_st, w_st_nx;

    logic [KW-1:0] w_key_live;
    logic          w_hit;
    logic [2:0]    w_row;
    logic          w_key_ld;
    logic          w_meta_ld;
    logic          w_data_ld;

    assign w_key_live = {vscan, hscan[HW-1:PXB]};

    jtframe_tilescan_cache #(
        .HKW  (HKW),
        .KW   (KW),
        .PALW (PALW),
        .PW   (PW)
    ) u_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key     (w_key_live),
        .i_key_ld  (w_key_ld),
        .i_pal     (map_data[CODEW +: PALW]),
`ifdef JTFRAME_TILESCAN_FLIP_EN
        .i_flip    (map_data[CODEW+PALW]),
`endif
        .i_meta_ld (w_meta_ld),
        .i_data    (rom_data),
        .i_data_ld (w_data_ld),
        .i_idx     (hscan[PXB-1:0]),
        .o_hit     (w_hit),
        .o_row     (w_row),
        .o_pxl     (pxl_data)
    );

    // Hits only count while no refill is in flight, so a stale row never shows.
    assign pxl_ok = w_hit && (r_st == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nx;
        end
    end

    always_comb begin
        w_st_nx   = r_st;
        w_key_ld  = 1'b0;
        w_meta_ld = 1'b0;
        w_data_ld = 1'b0;
        case (r_st)
            ST_IDLE: begin
                if (!w_hit) begin
                    w_key_ld = 1'b1;
                    w_st_nx  = ST_MAPWAIT;
                end
            end
            ST_MAPWAIT: begin
                w_meta_ld = 1'b1;
                w_st_nx   = ST_ROMREQ;
            end
            // rom_ok here may still belong to the previous address.
            ST_ROMREQ: begin
                w_st_nx = ST_ROMWAIT;
            end
            ST_ROMWAIT: begin
                if (rom_ok) begin
                    w_data_ld = 1'b1;
                    w_st_nx   = ST_IDLE;
                end
            end
            default: begin
                w_st_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_addr <= '0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
        end else begin
            if (w_key_ld) begin
                map_addr <= {vscan[VW-1:ROWB], hscan[HW-1:PXB]};
            end
            // The row comes from the captured key, not the live vscan.
            if (w_meta_ld) begin
                rom_addr <= {map_data[CODEW-1:0], w_row};
                rom_cs   <= 1'b1;
            end else if (w_data_ld) begin
                rom_cs   <= 1'b0;
            end
        end
    end

endmodule
